// File: rtl/pipe_mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory macro port and stall outputs of the
// unified-memory arbiter.
interface pipe_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

  // Pipeline plus memory macro side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage:
// data-first arbitration with an anti-starvation override, fixed-latency sequencing.
module pipe_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               CLK,
  input  logic               RST,
  pipe_mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned STV_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

  state_e            state_q;
  owner_e            owner_q;
  logic [CNT_W-1:0]  lat_q;
  logic [STV_W-1:0]  starve_q;
  logic              op_we_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic starved_c;
  logic grant_dm_c;
  logic grant_if_c;

  // Grant decision, only meaningful in IDLE.
  always_comb begin
    grant_dm_c = 1'b0;
    grant_if_c = 1'b0;
    starved_c  = bus.if_req && (starve_q == STV_W'(STARVE_MAX));
    if (state_q == S_IDLE) begin
      if (bus.dm_req && !starved_c) begin
        grant_dm_c = 1'b1;
      end else if (bus.if_req) begin
        grant_if_c = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      lat_q       <= '0;
      starve_q    <= '0;
      op_we_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses.
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_dm_c) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            op_we_q     <= bus.dm_we;
            owner_q     <= OWN_DM;
            lat_q       <= CNT_W'(MEM_LAT - 1);
            state_q     <= S_ACCESS;
            if (bus.if_req && (starve_q != STV_W'(STARVE_MAX))) begin
              starve_q <= starve_q + STV_W'(1);
            end
          end else if (grant_if_c) begin
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
            op_we_q    <= 1'b0;
            owner_q    <= OWN_IF;
            lat_q      <= CNT_W'(MEM_LAT - 1);
            starve_q   <= '0;
            state_q    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (lat_q == '0) begin
            state_q  <= S_RESP;
            if_ack_q <= (owner_q == OWN_IF);
            dm_ack_q <= (owner_q == OWN_DM);
          end else begin
            lat_q <= lat_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (if_ack_q) begin
            if_rdata_q <= bus.mem_rdata;
          end
          if (dm_ack_q && !op_we_q) begin
            dm_rdata_q <= bus.mem_rdata;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data bypasses its register in the ack cycle so the stage sees it immediately.
  assign bus.if_rdata  = if_ack_q ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata  = (dm_ack_q && !op_we_q) ? bus.mem_rdata : dm_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ack_q;

endmodule
